mtimer_multi: RTL and testbench
===============================

# mtimer_multi

Parametrised machine-timer unit holding one 64-bit `mtime` counter and `N_CMP` 64-bit `mtimecmp` comparators, memory-mapped over a 32-bit register port, with a programmable tick prescaler and one registered timer-interrupt line per comparator. It sits beside the CSR unit on the data-memory bus and drives `mip.mtip` for each hart or interrupt target.

## Interface
- `XLEN`, 32, data width of the register port (fixed at 32 in this generation)
- `N_CMP`, 2, number of `mtimecmp` comparators / `mtip` outputs (1..8)
- `PRESCALE_W`, 8, width of the prescaler divisor field
- `BASE_ADDR`, 32'h0000_8004, byte address of `mtime` low word
- `clk` input 1 system clock
- `rst_n` input 1 asynchronous active-low reset
- `wr_en` input 1 write strobe, one cycle per access
- `rd_en` input 1 read strobe, one cycle per access
- `addr` input 32 byte address, word aligned
- `wdata` input 32 write data
- `rdata` output 32 read data, valid with `rvalid`
- `rvalid` output 1 read-data valid pulse
- `addr_err` output 1 pulse: strobe to unmapped or misaligned address
- `mtip` output N_CMP per-comparator timer interrupt pending

## Operation
- Register map (offset from BASE_ADDR): 0x0 `mtime[31:0]`; 0x4 `mtime[63:32]`; 0x8+8i `mtimecmp_i[31:0]`; 0xC+8i `mtimecmp_i[63:32]`, i in 0..N_CMP-1; 0x8+8·N_CMP CTRL.
- CTRL: bit0 EN; bits[8+PRESCALE_W-1:8] DIV; all other bits read 0, writes ignored.
- Prescaler: counter `pc` of width PRESCALE_W. When EN=1: if `pc == DIV`, `pc <= 0` and `mtime <= mtime + 1`; else `pc <= pc + 1`. Tick period = DIV+1 cycles. EN=0 freezes `mtime` and `pc`. Writing CTRL clears `pc`.
- `mtime` is 64-bit unsigned, wraps 2^64-1 -> 0 with no flag.
- Software write to either `mtime` half replaces only that 32-bit half; on the same cycle as a tick, the write wins and no increment occurs (both halves retain/take written value; no carry into the unwritten half).
- Atomic read: reading `mtime` low latches `mtime[63:32]` into a shadow register in the same cycle; reading `mtime` high returns the shadow. Writing `mtime` high also loads the shadow with `wdata`.
- `mtimecmp_i` writes replace one 32-bit half; no side effects on `mtime`.
- `mtip[i] <= (mtime >= mtimecmp_i)`, unsigned 64-bit compare, registered every cycle; cleared only by raising `mtimecmp_i` or lowering `mtime`.
- `wr_en` and `rd_en` together on same address: write is performed, read returns pre-write value.
- Unmapped or `addr[1:0] != 0`: write ignored, read returns 0, `addr_err` pulses next cycle (with `rvalid` if a read).

## Timing
- Reset values: `mtime` = 0, all `mtimecmp_i` = 64'hFFFF_FFFF_FFFF_FFFF, shadow = 0, `pc` = 0, CTRL EN=1 DIV=0, `mtip` = 0, `rdata` = 0, `rvalid` = 0, `addr_err` = 0.
- Reset assertion mid-operation returns every register to reset value immediately (asynchronous); first tick occurs on first rising edge after deassertion.
- Read latency 1: strobe at edge N -> `rdata`/`rvalid` valid after edge N+1 for one cycle; `rdata` returns 0 when `rvalid` = 0.
- Write takes effect at the edge sampling `wr_en`; a read of the same register on the next cycle sees new value.
- `mtip` latency: 1 cycle after the `mtime`/`mtimecmp` change that satisfies (or breaks) the compare.
- Back-to-back strobes every cycle supported; no stalls.

## Test plan
- Reset, DIV=0: after 10 cycles `mtime` low reads 10 (±1 for read latency, checked against model); all `mtip` = 0; CTRL reads 0x1.
- Prescale: write CTRL = 0x0301 (DIV=3) -> `mtime` increments once every 4 cycles; write CTRL = 0x0 -> `mtime` frozen over 50 cycles.
- Carry / atomic read: write `mtime` high = 0, low = 0xFFFF_FFFE; read low then high across the rollover -> pair returns a consistent 64-bit value (0x0_FFFF_FFFF or 0x1_0000_0000 family, never 0x1_FFFF_FFFF).
- Compare: `mtimecmp_1` = 0x0000_0000_0000_0064; `mtip[1]` rises exactly 1 cycle after `mtime` reaches 100, `mtip[0]` stays 0; writing `mtimecmp_1` high = 1 clears `mtip[1]` next cycle.
- Collision: write `mtime` low = 0x55 on a tick cycle -> next read returns 0x55 (+ later ticks only); simultaneous read/write returns old value.
- Errors and reset: read at BASE_ADDR+0x2 and beyond CTRL -> `rdata` 0, `addr_err` pulse; assert `rst_n` low mid-count -> all outputs 0, `mtimecmp` reads all-ones.

Source files
------------

// File: rtl/mtimer_multi.sv
// Machine timer: one 64-bit mtime counter with a programmable prescaler and
// N_CMP mtimecmp comparators, each driving a registered mtip line.
module mtimer_multi #(
    parameter int          XLEN       = 32,
    parameter int          N_CMP      = 2,
    parameter int          PRESCALE_W = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8004
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [31:0]      addr,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata,
    output logic             rvalid,
    output logic             addr_err,
    output logic [N_CMP-1:0] mtip
);

    // Access protocol: wr_en/rd_en are single-cycle strobes with no backpressure.
    // A write commits at the sampling edge; a read returns the pre-write value
    // on rdata with rvalid exactly one cycle later; rdata is 0 whenever rvalid is 0.

    localparam logic [29:0] CTRL_IDX = 30'(2 + 2 * N_CMP);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp [N_CMP];
    logic [31:0]           shadow;
    logic [PRESCALE_W-1:0] pc;
    logic                  ctrl_en;
    logic [PRESCALE_W-1:0] ctrl_div;

    logic [31:0]     off;
    logic [29:0]     word_idx;
    logic            mapped;
    logic            wr_mtime_lo;
    logic            wr_mtime_hi;
    logic            rd_mtime_lo;
    logic            wr_ctrl;
    logic            tick;
    logic [XLEN-1:0] ctrl_val;
    logic [XLEN-1:0] rd_mux;

    assign off         = addr - BASE_ADDR;
    assign word_idx    = off[31:2];
    assign mapped      = (off[1:0] == 2'b00) && (word_idx <= CTRL_IDX);
    assign wr_mtime_lo = wr_en && mapped && (word_idx == 30'd0);
    assign wr_mtime_hi = wr_en && mapped && (word_idx == 30'd1);
    assign rd_mtime_lo = rd_en && mapped && (word_idx == 30'd0);
    assign wr_ctrl     = wr_en && mapped && (word_idx == CTRL_IDX);
    assign tick        = ctrl_en && (pc == ctrl_div);
    assign ctrl_val    = XLEN'(ctrl_en) | (XLEN'(ctrl_div) << 8);

    always_comb begin
        rd_mux = '0;
        if (word_idx == 30'd0) begin
            rd_mux = mtime[31:0];
        end else if (word_idx == 30'd1) begin
            rd_mux = shadow;
        end else if (word_idx == CTRL_IDX) begin
            rd_mux = ctrl_val;
        end else begin
            for (int i = 0; i < N_CMP; i++) begin
                if (word_idx == 30'(2 + 2 * i)) rd_mux = mtimecmp[i][31:0];
                if (word_idx == 30'(3 + 2 * i)) rd_mux = mtimecmp[i][63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime    <= '0;
            shadow   <= '0;
            pc       <= '0;
            ctrl_en  <= 1'b1;
            ctrl_div <= '0;
            mtip     <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
            for (int i = 0; i < N_CMP; i++) mtimecmp[i] <= '1;
        end else begin
            // The tick uses the prescaler settings in force before a CTRL write.
            if (wr_ctrl) begin
                pc <= '0;
            end else if (ctrl_en) begin
                pc <= tick ? '0 : pc + 1'b1;
            end

            // A software write to either half wins over a same-cycle tick.
            if (wr_mtime_lo) begin
                mtime[31:0] <= wdata;
            end else if (wr_mtime_hi) begin
                mtime[63:32] <= wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_mtime_hi) begin
                shadow <= wdata;
            end else if (rd_mtime_lo) begin
                shadow <= mtime[63:32];
            end

            if (wr_ctrl) begin
                ctrl_en  <= wdata[0];
                ctrl_div <= wdata[8 +: PRESCALE_W];
            end

            for (int i = 0; i < N_CMP; i++) begin
                if (wr_en && mapped && (word_idx == 30'(2 + 2 * i)))
                    mtimecmp[i][31:0] <= wdata;
                if (wr_en && mapped && (word_idx == 30'(3 + 2 * i)))
                    mtimecmp[i][63:32] <= wdata;
                mtip[i] <= (mtime >= mtimecmp[i]);
            end

            rvalid   <= rd_en;
            rdata    <= (rd_en && mapped) ? rd_mux : '0;
            addr_err <= (rd_en || wr_en) && !mapped;
        end
    end

endmodule

// File: tb/tb_mtimer_multi.sv
// Bench for mtimer_multi: directed accesses push expected responses into a
// queue that a negedge monitor pops whenever the DUT presents rvalid/addr_err.
module tb_mtimer_multi;

  localparam logic [31:0] MTIME_LO = 32'h0000_8004;
  localparam logic [31:0] MTIME_HI = 32'h0000_8008;
  localparam logic [31:0] CMP0_LO  = 32'h0000_800C;
  localparam logic [31:0] CMP0_HI  = 32'h0000_8010;
  localparam logic [31:0] CMP1_LO  = 32'h0000_8014;
  localparam logic [31:0] CMP1_HI  = 32'h0000_8018;
  localparam logic [31:0] CTRL     = 32'h0000_801C;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        addr_err;
  logic [1:0]  mtip;

  logic [33:0] exp_q[$];
  logic [31:0] tag_q[$];
  int errors = 0;
  int checks = 0;

  mtimer_multi #(
    .XLEN(32), .N_CMP(2), .PRESCALE_W(8), .BASE_ADDR(32'h0000_8004)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .addr_err(addr_err), .mtip(mtip)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: entered at a negedge, each consumes exactly one clock
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic err);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back({1'b1, err, err ? 32'h0 : e});
    tag_q.push_back(a);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic err);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    if (err) begin
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      tag_q.push_back(a);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = a;
    wdata = d;
    exp_q.push_back({1'b1, 1'b0, e});
    tag_q.push_back(a);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_mtip(input string name, input logic [1:0] e);
    checks++;
    if (mtip !== e) begin
      errors++;
      $display("FAIL %s mtip got=%b exp=%b", name, mtip, e);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({rvalid, addr_err, rdata, mtip} !== 36'h0) begin
      errors++;
      $display("FAIL %s rvalid=%b addr_err=%b rdata=%h mtip=%b exp all zero",
               name, rvalid, addr_err, rdata, mtip);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [33:0] got;
    logic [33:0] exp;
    logic [31:0] tag;
    got = {rvalid, addr_err, rdata};
    checks++;
    if (rvalid || addr_err) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got rvalid=%b err=%b rdata=%h", rvalid, addr_err, rdata);
      end else begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL resp@%h got rvalid=%b err=%b rdata=%h exp rvalid=%b err=%b rdata=%h",
                   tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
      end
    end else if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_rdata got=%h exp=0", rdata);
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    idle(3);
    check_idle_outputs("reset_hold");
    rst_n = 1'b1;

    // DIV=0: mtime counts every edge from the first edge after release
    idle(9);
    rd(MTIME_LO, 32'd9, 1'b0);
    rd(CTRL, 32'h1, 1'b0);
    check_mtip("reset_mtip", 2'b00);
    rd(CMP0_LO, 32'hFFFF_FFFF, 1'b0);
    rd(MTIME_HI, 32'h0, 1'b0);

    // DIV=3: one increment per 4 cycles
    wr(CTRL, 32'h0000_0301, 1'b0);
    wr(MTIME_LO, 32'h0, 1'b0);
    rd(MTIME_LO, 32'd0, 1'b0);
    rd(MTIME_LO, 32'd0, 1'b0);
    rd(MTIME_LO, 32'd0, 1'b0);
    rd(MTIME_LO, 32'd1, 1'b0);
    rd(MTIME_LO, 32'd1, 1'b0);
    rd(MTIME_LO, 32'd1, 1'b0);
    rd(MTIME_LO, 32'd1, 1'b0);
    rd(MTIME_LO, 32'd2, 1'b0);
    rd(CTRL, 32'h0000_0301, 1'b0);

    // EN=0 freezes mtime
    wr(CTRL, 32'h0, 1'b0);
    idle(50);
    rd(MTIME_LO, 32'd2, 1'b0);
    rd(CTRL, 32'h0, 1'b0);

    // carry and atomic low/high read across the 32-bit rollover
    wr(MTIME_HI, 32'h0, 1'b0);
    wr(MTIME_LO, 32'hFFFF_FFFE, 1'b0);
    wr(CTRL, 32'h1, 1'b0);
    idle(1);
    rd(MTIME_LO, 32'hFFFF_FFFF, 1'b0);
    rd(MTIME_HI, 32'h0, 1'b0);
    rd(MTIME_LO, 32'h0000_0001, 1'b0);
    rd(MTIME_HI, 32'h0000_0001, 1'b0);

    // compare: mtimecmp_1 = 100
    wr(MTIME_HI, 32'h0, 1'b0);
    wr(MTIME_LO, 32'h0, 1'b0);
    wr(CMP1_LO, 32'h64, 1'b0);
    wr(CMP1_HI, 32'h0, 1'b0);
    idle(98);
    check_mtip("cmp_before", 2'b00);
    idle(1);
    check_mtip("cmp_rise", 2'b10);
    wr(CMP1_HI, 32'h1, 1'b0);
    check_mtip("cmp_hold", 2'b10);
    idle(1);
    check_mtip("cmp_clear", 2'b00);
    rd(CMP1_HI, 32'h1, 1'b0);
    rd(CMP1_LO, 32'h64, 1'b0);

    // collision: write on a tick cycle wins; read+write returns old value
    wr(MTIME_LO, 32'h55, 1'b0);
    rd(MTIME_LO, 32'h55, 1'b0);
    rd(MTIME_LO, 32'h56, 1'b0);
    rw(MTIME_LO, 32'h1000, 32'h57);
    rd(MTIME_LO, 32'h1000, 1'b0);
    rd(MTIME_HI, 32'h0, 1'b0);

    // address errors
    rd(32'h0000_8006, 32'h0, 1'b1);
    rd(32'h0000_8020, 32'h0, 1'b1);
    rd(32'h0000_8000, 32'h0, 1'b1);
    wr(32'h0000_8020, 32'h0, 1'b1);
    wr(32'h0000_801E, 32'h0, 1'b1);
    rd(CTRL, 32'h1, 1'b0);

    // asynchronous reset mid-count with mtip[0] set
    wr(CMP0_LO, 32'h0, 1'b0);
    wr(CMP0_HI, 32'h0, 1'b0);
    idle(2);
    check_mtip("cmp0_zero", 2'b01);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    idle(2);
    rst_n = 1'b1;
    rd(MTIME_LO, 32'd0, 1'b0);
    rd(MTIME_LO, 32'd1, 1'b0);
    rd(CMP0_LO, 32'hFFFF_FFFF, 1'b0);
    rd(CMP0_HI, 32'hFFFF_FFFF, 1'b0);
    rd(CMP1_HI, 32'hFFFF_FFFF, 1'b0);
    rd(CTRL, 32'h1, 1'b0);
    rd(MTIME_HI, 32'h0, 1'b0);
    check_mtip("post_reset_mtip", 2'b00);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
